confreg: RTL

Memory-mapped configuration/peripheral register block on the CPU data path, downstream of `mycpu_pipeline`'s data port. The interconnect routes confreg-window accesses here instead of data SRAM. Provides a free-running machine timer with compare interrupt (`timer_int` back to the pipeline) and a buffered UART console driving the top-level `io_uart_*` pins. Port timing matches the `sram` block: one-cycle registered read data, byte write enables.

---
 rtl/confreg_pkg.sv | 33 +++
 rtl/conf_fifo.sv | 46 ++++
 rtl/confreg.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/confreg_pkg.sv
// confreg_pkg: register offsets, UART_STAT bit positions, TX FSM states and a byte-lane merge helper
// shared by the confreg block and its bench.
package confreg_pkg;

    localparam logic [2:0] CONF_MTIME     = 3'd0;
    localparam logic [2:0] CONF_MTIMECMP  = 3'd1;
    localparam logic [2:0] CONF_UART_TX   = 3'd2;
    localparam logic [2:0] CONF_UART_STAT = 3'd3;
    localparam logic [2:0] CONF_UART_RX   = 3'd4;
    localparam logic [2:0] CONF_SCRATCH   = 3'd5;

    localparam int STAT_TX_FULL      = 0;
    localparam int STAT_TX_EMPTY     = 1;
    localparam int STAT_RX_VALID     = 2;
    localparam int STAT_TX_COUNT_LSB = 8;

    typedef enum logic {
        ST_IDLE,
        ST_GAP
    } tx_state_t;

    // Lanes with a set enable take the new byte, the rest keep the old one.
    function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  wen);
        logic [63:0] merged;
        for (int i = 0; i < 8; i++) begin
            merged[i*8 +: 8] = wen[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/conf_fifo.sv
// conf_fifo: synchronous byte FIFO for the confreg UART transmitter.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module conf_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/confreg.sv
// confreg: memory-mapped machine timer and buffered UART console with one-cycle registered reads.
// The UART receive path exists only when CONFREG_UART_RX_EN is defined.
module confreg
    import confreg_pkg::*;
#(
    parameter int TX_DEPTH = 8,
    parameter int TX_GAP   = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        conf_en,
    input  logic [7:0]  conf_wen,
    input  logic [63:0] conf_addr,
    input  logic [63:0] conf_wdata,
    output logic [63:0] conf_rdata,
    output logic        stallreq_conf,
    output logic        timer_int,
    output logic        uart_out_valid,
    output logic [7:0]  uart_out_ch,
    input  logic        uart_in_valid,
    input  logic [7:0]  uart_in_ch
);
    localparam int CW = $clog2(TX_DEPTH) + 1;
    localparam int GW = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;

    logic [2:0]    sel;
    logic          wr;
    logic          rd;
    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic [63:0]   scratch;
    logic [63:0]   stat;
    logic [63:0]   rd_mux;
    logic          tx_push_req;
    logic          tx_push;
    logic          tx_pop;
    logic          tx_full;
    logic          tx_empty;
    logic [7:0]    tx_head;
    logic [CW-1:0] tx_count;
    tx_state_t     tx_state;
    logic [GW-1:0] gap_cnt;
    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic          unused_addr;

    assign sel         = conf_addr[5:3];
    assign unused_addr = ^{conf_addr[63:6], conf_addr[2:0]};
    assign wr          = conf_en && (conf_wen != 8'd0);
    assign rd          = conf_en && (conf_wen == 8'd0);

    // A push against a full FIFO stalls even if the drain pops this cycle.
    assign tx_push_req   = wr && (sel == CONF_UART_TX) && conf_wen[0];
    assign tx_push       = tx_push_req && !tx_full;
    assign tx_pop        = (tx_state == ST_IDLE) && !tx_empty;
    assign stallreq_conf = !reset && tx_push_req && tx_full;

    conf_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_push),
        .push_data (conf_wdata[7:0]),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            scratch   <= '0;
            timer_int <= 1'b0;
        end else begin
            if (wr && (sel == CONF_MTIME))
                mtime <= byte_merge(mtime + 64'd1, conf_wdata, conf_wen);
            else
                mtime <= mtime + 64'd1;
            if (wr && (sel == CONF_MTIMECMP))
                mtimecmp <= byte_merge(mtimecmp, conf_wdata, conf_wen);
            if (wr && (sel == CONF_SCRATCH))
                scratch <= byte_merge(scratch, conf_wdata, conf_wen);
            timer_int <= (mtime >= mtimecmp);
        end
    end

`ifdef CONFREG_UART_RX_EN
    // A byte arriving alongside an RX read wins, so it is not lost to the clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_valid <= 1'b0;
            rx_byte  <= 8'd0;
        end else if (uart_in_valid) begin
            rx_valid <= 1'b1;
            rx_byte  <= uart_in_ch;
        end else if (rd && (sel == CONF_UART_RX)) begin
            rx_valid <= 1'b0;
        end
    end
`else
    logic unused_rx;
    assign unused_rx = ^{uart_in_valid, uart_in_ch};
    assign rx_valid  = 1'b0;
    assign rx_byte   = 8'd0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state       <= ST_IDLE;
            gap_cnt        <= '0;
            uart_out_valid <= 1'b0;
            uart_out_ch    <= 8'd0;
        end else begin
            uart_out_valid <= 1'b0;
            case (tx_state)
                ST_IDLE: begin
                    if (tx_pop) begin
                        uart_out_valid <= 1'b1;
                        uart_out_ch    <= tx_head;
                        gap_cnt        <= GW'(TX_GAP);
                        if (TX_GAP != 0) tx_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt - GW'(1);
                    if (gap_cnt <= GW'(1)) tx_state <= ST_IDLE;
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        stat                                = '0;
        stat[STAT_TX_FULL]                  = tx_full;
        stat[STAT_TX_EMPTY]                 = tx_empty;
        stat[STAT_RX_VALID]                 = rx_valid;
        stat[STAT_TX_COUNT_LSB +: 8]        = 8'(tx_count);
        rd_mux = '0;
        case (sel)
            CONF_MTIME:     rd_mux = mtime;
            CONF_MTIMECMP:  rd_mux = mtimecmp;
            CONF_UART_STAT: rd_mux = stat;
            CONF_UART_RX:   rd_mux = {56'd0, rx_byte};
            CONF_SCRATCH:   rd_mux = scratch;
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)   conf_rdata <= '0;
        else if (rd) conf_rdata <= rd_mux;
    end

endmodule
